// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-interface round-robin arbiter.
package reg_arb_pkg;

  localparam int RegAw   = 32;
  localparam int RegDw   = 32;
  localparam int RegSw   = RegDw / 8;
  localparam int MaxReq  = 32;
  localparam int MaxIdxW = $clog2(MaxReq);

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [RegAw-1:0] addr;
    logic             write;
    logic [RegDw-1:0] wdata;
    logic [RegSw-1:0] wstrb;
    logic             valid;
  } req_t;

  typedef struct packed {
    logic [RegDw-1:0] rdata;
    logic             error;
    logic             ready;
  } rsp_t;

  // First set bit of valid_vec scanning ptr, ptr+1, ... modulo n.
  // Scanning backwards lets the earliest candidate overwrite later ones.
  function automatic int rr_pick(input logic [MaxReq-1:0] valid_vec, input int ptr, input int n);
    int pick;
    int idx;
    pick = 0;
    for (int k = n - 1; k >= 0; k--) begin
      idx = (ptr + k) % n;
      if (valid_vec[idx[MaxIdxW-1:0]]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/reg_rr_arbiter_if.sv
// Bundle of master-side and slave-side register buses around the arbiter.
interface reg_rr_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int NumReq = 2
) ();

  req_t [NumReq-1:0] req_i;
  rsp_t [NumReq-1:0] rsp_o;
  req_t              req_o;
  rsp_t              rsp_i;

  modport slave (
    input  req_i,
    input  rsp_i,
    output req_o,
    output rsp_o
  );

  modport master (
    output req_i,
    output rsp_i,
    input  req_o,
    input  rsp_o
  );

endinterface

// File: rtl/reg_arb_timeout_cnt.sv
// Stall counter for a granted transfer; expired_o flags the last allowed wait cycle.
module reg_arb_timeout_cnt #(
  parameter int TimeoutCycles = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (clr_i) begin
      tmo_cnt_d = '0;
    end else if (en_i) begin
      tmo_cnt_d = tmo_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Constant-false when the timeout is disabled.
  assign expired_o = (TimeoutCycles > 0) && (tmo_cnt_q == LastCnt);

endmodule

// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter sharing one register slave among NumReq masters,
// with zero-latency grant in IDLE and an optional stall timeout.
module reg_rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int              NumReq        = 2,
  parameter int              DW            = 32,
  parameter int              TimeoutCycles = 0,
  parameter logic [DW-1:0]   ErrVal        = 32'hBADCAB1E
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  reg_rr_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NumReq);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     win;
  logic [NumReq-1:0] valid_vec;
  logic              tmo_clr, tmo_en, tmo_expired;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_vld
    assign valid_vec[gi] = bus.req_i[gi].valid;
  end

  assign win = IW'(rr_pick(MaxReq'(valid_vec), int'(rr_ptr_q), NumReq));

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(NumReq - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    bus.req_o = '0;
    bus.rsp_o = '0;
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_clr   = 1'b0;
    tmo_en    = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (|valid_vec) begin
          bus.req_o      = bus.req_i[win];
          bus.rsp_o[win] = bus.rsp_i;
          if (bus.rsp_i.ready) begin
            rr_ptr_d = next_idx(win);
          end else begin
            gnt_d   = win;
            tmo_clr = 1'b1;
            state_d = ARB_BUSY;
          end
        end
      end
      ARB_BUSY: begin
        bus.req_o = bus.req_i[gnt_q];
        if (!bus.req_i[gnt_q].valid) begin
          // Master withdrew its request: drop silently, keep priority.
          state_d = ARB_IDLE;
        end else begin
          // Abort decision uses only registered state so req_o never depends on rsp_i.
          if (tmo_expired) bus.req_o.valid = 1'b0;
          if (bus.rsp_i.ready) begin
            bus.rsp_o[gnt_q] = bus.rsp_i;
            rr_ptr_d         = next_idx(gnt_q);
            state_d          = ARB_IDLE;
          end else if (tmo_expired) begin
            bus.rsp_o[gnt_q].rdata = RegDw'(ErrVal);
            bus.rsp_o[gnt_q].error = 1'b1;
            bus.rsp_o[gnt_q].ready = 1'b1;
            rr_ptr_d               = next_idx(gnt_q);
            state_d                = ARB_IDLE;
          end else begin
            bus.rsp_o[gnt_q] = bus.rsp_i;
            tmo_en           = 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (!rst_ni) begin
      bus.req_o = '0;
      bus.rsp_o = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  reg_arb_timeout_cnt #(
    .TimeoutCycles(TimeoutCycles)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Directed bench for reg_rr_arbiter: expected responses queued at drive time, checked on ready.
module tb_reg_rr_arbiter;
  import reg_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_rr_arbiter_if #(.NumReq(2)) bus ();

  reg_rr_arbiter #(
    .NumReq       (2),
    .DW           (32),
    .TimeoutCycles(4),
    .ErrVal       (32'hBADCAB1E)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt[2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mkreq(input logic [31:0] a);
    req_t r;
    r       = '0;
    r.addr  = a;
    r.valid = 1'b1;
    return r;
  endfunction

  function automatic rsp_t mkrsp(input logic [31:0] d, input logic rdy);
    rsp_t r;
    r.rdata = d;
    r.error = 1'b0;
    r.ready = rdy;
    return r;
  endfunction

  task automatic expect_rsp(input int m, input logic [31:0] d, input logic e);
    exp_t x;
    x.m     = m;
    x.rdata = d;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic observe();
    exp_t x;
    for (int m = 0; m < 2; m++) begin
      if (bus.rsp_o[m].ready === 1'b1) begin
        $display("[TB] t=%0t rsp master=%0d rdata=%h error=%b", $time, m,
                 bus.rsp_o[m].rdata, bus.rsp_o[m].error);
        if (sb.size() == 0) begin
          chk("unexpected_rsp_master", m, 32'hFFFF_FFFF);
        end else begin
          x = sb.pop_front();
          chk("rsp_master", m, x.m);
          chk("rsp_rdata", bus.rsp_o[m].rdata, x.rdata);
          chk("rsp_error", bus.rsp_o[m].error, x.err);
          done_cnt[m]++;
        end
      end
    end
  endtask

  task automatic settle();
    #1;
    observe();
  endtask

  task automatic idle_in();
    bus.req_i = '0;
    bus.rsp_i = '0;
  endtask

  initial begin
    idle_in();
    #2;
    chk("reset_req_o", bus.req_o, '0);
    chk("reset_rsp_o", bus.rsp_o, '0);
    chk("reset_state", dut.state_q, ARB_IDLE);
    chk("reset_rr_ptr", dut.rr_ptr_q, 0);
    chk("reset_gnt", dut.gnt_q, 0);
    chk("reset_tmo_cnt", dut.u_tmo.tmo_cnt_q, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single zero-latency transfer
    @(negedge clk);
    bus.req_i[0] = mkreq(32'h10);
    bus.rsp_i    = mkrsp(32'h1234, 1'b1);
    expect_rsp(0, 32'h1234, 1'b0);
    settle();
    chk("t1_req_o", bus.req_o, mkreq(32'h10));
    chk("t1_rsp1_zero", bus.rsp_o[1], '0);
    @(negedge clk);
    idle_in();
    settle();
    chk("t1_rr_ptr", dut.rr_ptr_q, 1);
    chk("t1_state", dut.state_q, ARB_IDLE);
    chk("t1_sb_drain", sb.size(), 0);

    // 2: both masters, slave always ready -> alternate from rr_ptr=1
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.req_i[0] = mkreq(32'h20);
      bus.req_i[1] = mkreq(32'h30);
      bus.rsp_i    = mkrsp(32'h100 + k, 1'b1);
      expect_rsp((k % 2 == 0) ? 1 : 0, 32'h100 + k, 1'b0);
      settle();
      chk("t2_req_addr", bus.req_o.addr, (k % 2 == 0) ? 32'h30 : 32'h20);
    end
    chk("t2_done_m0", done_cnt[0], 2);
    chk("t2_done_m1", done_cnt[1], 2);
    @(negedge clk);
    idle_in();
    settle();
    chk("t2_rr_ptr", dut.rr_ptr_q, 1);

    // 3: master1 granted, slave stalls, master0 ignored while BUSY
    @(negedge clk);
    bus.req_i[1] = mkreq(32'h40);
    settle();
    chk("t3_grant_addr", bus.req_o.addr, 32'h40);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_busy", dut.state_q, ARB_BUSY);
      bus.req_i[0] = mkreq(32'h50);
      if (k == 2) begin
        bus.rsp_i = mkrsp(32'hAA, 1'b1);
        expect_rsp(1, 32'hAA, 1'b0);
      end
      settle();
      chk("t3_req_stable", bus.req_o, mkreq(32'h40));
      chk("t3_rsp0_zero", bus.rsp_o[0], '0);
    end
    @(negedge clk);
    idle_in();
    settle();
    chk("t3_state", dut.state_q, ARB_IDLE);
    chk("t3_rr_ptr", dut.rr_ptr_q, 0);
    chk("t3_sb_drain", sb.size(), 0);

    // 4: timeout abort on 4th BUSY cycle, then the other master wins
    @(negedge clk);
    bus.req_i[0] = mkreq(32'h60);
    bus.req_i[1] = mkreq(32'h70);
    settle();
    chk("t4_grant_addr", bus.req_o.addr, 32'h60);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) expect_rsp(0, 32'hBADCAB1E, 1'b1);
      settle();
      chk("t4_req_valid", bus.req_o.valid, (k == 4) ? 1'b0 : 1'b1);
    end
    @(negedge clk);
    chk("t4_state", dut.state_q, ARB_IDLE);
    chk("t4_rr_ptr", dut.rr_ptr_q, 1);
    bus.rsp_i = mkrsp(32'h77, 1'b1);
    expect_rsp(1, 32'h77, 1'b0);
    settle();
    chk("t4_next_grant", bus.req_o.addr, 32'h70);
    @(negedge clk);
    idle_in();
    settle();
    chk("t4_sb_drain", sb.size(), 0);

    // 5: ready exactly on the 4th BUSY cycle beats the timeout
    @(negedge clk);
    bus.req_i[0] = mkreq(32'h80);
    settle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) begin
        bus.rsp_i = mkrsp(32'h55, 1'b1);
        expect_rsp(0, 32'h55, 1'b0);
      end
      settle();
    end
    @(negedge clk);
    idle_in();
    settle();
    chk("t5_state", dut.state_q, ARB_IDLE);
    chk("t5_rr_ptr", dut.rr_ptr_q, 1);
    chk("t5_sb_drain", sb.size(), 0);

    // 6: async reset mid-transfer
    @(negedge clk);
    bus.req_i[1] = mkreq(32'h90);
    settle();
    @(negedge clk);
    settle();
    chk("t6_busy", dut.state_q, ARB_BUSY);
    @(negedge clk);
    bus.req_i[0] = mkreq(32'hA0);
    rst_n = 1'b0;
    settle();
    chk("t6_rst_req_o", bus.req_o, '0);
    chk("t6_rst_rsp_o", bus.rsp_o, '0);
    chk("t6_rst_state", dut.state_q, ARB_IDLE);
    chk("t6_rst_rr_ptr", dut.rr_ptr_q, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    bus.rsp_i = mkrsp(32'h66, 1'b1);
    expect_rsp(0, 32'h66, 1'b0);
    settle();
    chk("t6_prio_m0", bus.req_o.addr, 32'hA0);
    @(negedge clk);
    idle_in();
    settle();
    chk("t6_sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
